// File: rtl/lap_timer.sv
// lap_timer: BCD race lap timer with last/best lap capture, lap counting and re-trigger guard.
module lap_timer #(
  parameter int CLK_HZ        = 65000000,
  parameter int TICK_HZ       = 100,
  parameter int N_LAPS        = 3,
  parameter int MIN_LAP_TICKS = 200
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        start,
  input  logic        pause,
  input  logic        lap_cross,
  output logic [23:0] current_time,
  output logic [23:0] last_time,
  output logic [23:0] best_time,
  output logic        best_valid,
  output logic [3:0]  lap_num,
  output logic        running,
  output logic        race_done,
  output logic        new_best
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = DIV > 1 ? $clog2(DIV) : 1;
  localparam int GW  = MIN_LAP_TICKS > 0 ? $clog2(MIN_LAP_TICKS + 1) : 1;
  localparam logic [23:0] T_MAX = 24'h995999;
  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, FINISHED} state_t;
  state_t state, state_nx;
  logic [PW-1:0] psc;
  logic [GW-1:0] guard;
  logic tick, accept, better, last_lap;
  function automatic logic [23:0] bcd_inc(input logic [23:0] t);
    logic [23:0] r;
    logic c;
    r = t;
    c = 1'b1;
    for (int i = 0; i < 6; i++)
      if (c) begin
        if (r[4*i +: 4] == ((i == 3) ? 4'd5 : 4'd9)) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    return r;
  endfunction
  always_comb begin
    tick     = state == RUNNING && !pause && psc == PW'(DIV - 1);
    accept   = state == RUNNING && lap_cross && !start && guard == GW'(MIN_LAP_TICKS);
    better   = !best_valid || current_time < best_time;
    last_lap = lap_num == 4'(N_LAPS);
    running  = state == RUNNING;
    race_done = state == FINISHED;
    state_nx = start ? RUNNING :
               (accept && last_lap) ? FINISHED :
               (state == RUNNING && pause) ? PAUSED :
               (state == PAUSED && !pause) ? RUNNING : state;
  end
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      psc          <= '0;
      guard        <= '0;
      current_time <= '0;
      last_time    <= '0;
      best_time    <= '0;
      best_valid   <= 1'b0;
      lap_num      <= '0;
      new_best     <= 1'b0;
    end else begin
      state    <= state_nx;
      new_best <= accept && better;
      if (start) begin
        current_time <= '0;
        last_time    <= '0;
        lap_num      <= 4'd1;
        guard        <= '0;
        psc          <= '0;
      end else if (accept) begin
        last_time <= current_time;
        if (better) begin
          best_time  <= current_time;
          best_valid <= 1'b1;
        end
        // the final lap freezes current_time; earlier laps start the next one
        if (!last_lap) begin
          current_time <= '0;
          lap_num      <= lap_num + 4'd1;
          guard        <= '0;
          psc          <= '0;
        end
      end else if (tick) begin
        psc <= '0;
        if (current_time != T_MAX) current_time <= bcd_inc(current_time);
        if (guard != GW'(MIN_LAP_TICKS)) guard <= guard + GW'(1);
      end else if (state == RUNNING && !pause) begin
        psc <= psc + PW'(1);
      end
    end
  end
endmodule

// File: tb/tb_lap_timer.sv
// tb_lap_timer: randomized scoreboard bench for lap_timer against a centisecond-count reference model.
module tb_lap_timer;
  localparam int N_LAPS = 2;
  localparam int MIN_T  = 5;
  localparam int DIV    = 10;
  localparam int TMAX   = 599999;
  typedef struct packed {
    logic [23:0] cur;
    logic [23:0] last;
    logic [23:0] best;
    logic        bv;
    logic [3:0]  lap;
    logic        run;
    logic        done;
    logic        nb;
  } snap_t;
  logic pclk = 1'b0, rst = 1'b1, start = 1'b0, pause = 1'b0, lap_cross = 1'b0;
  logic force_sat = 1'b0;
  logic [23:0] current_time, last_time, best_time;
  logic best_valid, running, race_done, new_best;
  logic [3:0] lap_num;
  snap_t exp_q[$];
  int passed = 0, total = 0;
  int m_st, m_t, m_last, m_best, m_lap, m_ph, m_g;
  logic m_bv, m_nb;
  lap_timer #(.CLK_HZ(1000), .TICK_HZ(100), .N_LAPS(N_LAPS), .MIN_LAP_TICKS(MIN_T)) dut (
    .pclk(pclk), .rst(rst), .start(start), .pause(pause), .lap_cross(lap_cross),
    .current_time(current_time), .last_time(last_time), .best_time(best_time),
    .best_valid(best_valid), .lap_num(lap_num), .running(running),
    .race_done(race_done), .new_best(new_best)
  );
  always #5 pclk = ~pclk;
  function automatic logic [23:0] to_bcd(input int t);
    int mm, ss, cc;
    mm = t / 6000;
    ss = (t / 100) % 60;
    cc = t % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction
  // reference model: state 0 idle, 1 running, 2 paused, 3 finished; times in centiseconds
  always @(posedge pclk or posedge rst) begin
    if (rst) begin
      m_st = 0; m_t = 0; m_last = 0; m_best = 0; m_lap = 0; m_ph = 0; m_g = 0;
      m_bv = 1'b0; m_nb = 1'b0;
    end else begin
      m_nb = 1'b0;
      if (force_sat) m_t = TMAX - 1;
      if (start) begin
        m_st = 1; m_t = 0; m_last = 0; m_lap = 1; m_g = 0; m_ph = 0;
      end else if (m_st == 1) begin
        if (lap_cross && m_g >= MIN_T) begin
          m_last = m_t;
          if (!m_bv || m_t < m_best) begin
            m_best = m_t; m_bv = 1'b1; m_nb = 1'b1;
          end
          if (m_lap < N_LAPS) begin
            m_t = 0; m_lap++; m_g = 0; m_ph = 0;
            if (pause) m_st = 2;
          end else m_st = 3;
        end else if (pause) m_st = 2;
        else if (m_ph == DIV - 1) begin
          m_ph = 0;
          if (m_t < TMAX) m_t++;
          if (m_g < MIN_T) m_g++;
        end else m_ph++;
      end else if (m_st == 2 && !pause) m_st = 1;
    end
    if (pclk)
      exp_q.push_back({to_bcd(m_t), to_bcd(m_last), to_bcd(m_best), m_bv, 4'(m_lap),
                       m_st == 1, m_st == 3, m_nb});
  end
  always @(posedge pclk) begin
    snap_t a, e;
    #1;
    a = {current_time, last_time, best_time, best_valid, lap_num, running, race_done, new_best};
    total++;
    if (exp_q.size() == 0) $display("FAIL scoreboard_empty t=%0t got %h", $time, a);
    else begin
      e = exp_q.pop_front();
      if (a === e) passed++;
      else $display("FAIL outputs t=%0t got cur=%h last=%h best=%h bv=%b lap=%0d run=%b done=%b nb=%b exp cur=%h last=%h best=%h bv=%b lap=%0d run=%b done=%b nb=%b",
                    $time, a.cur, a.last, a.best, a.bv, a.lap, a.run, a.done, a.nb,
                    e.cur, e.last, e.best, e.bv, e.lap, e.run, e.done, e.nb);
    end
  end
  task automatic pulse(input logic s, input logic l);
    start = s;
    lap_cross = l;
    @(negedge pclk);
    start = 1'b0;
    lap_cross = 1'b0;
  endtask
  task automatic ticks(input int n);
    repeat (n * DIV) @(negedge pclk);
  endtask
  initial begin
    repeat (3) @(negedge pclk);
    rst = 1'b0;
    @(negedge pclk);
    pulse(1, 0); ticks(1234);
    pulse(1, 0); ticks(3); pulse(0, 1); ticks(697); pulse(0, 1);
    ticks(650); pulse(0, 1); ticks(50); pulse(0, 1); ticks(3);
    pulse(1, 0); ticks(800); pulse(0, 1); ticks(650); pulse(0, 1); ticks(2);
    pulse(1, 0); ticks(300); pause = 1'b1;
    repeat (50) @(negedge pclk);
    pulse(0, 1);
    repeat (49) @(negedge pclk);
    pause = 1'b0; ticks(100); pulse(0, 1); ticks(20);
    pulse(1, 1); pause = 1'b1; pulse(1, 0); repeat (20) @(negedge pclk); pause = 1'b0; ticks(10);
    repeat (10000) begin
      @(negedge pclk);
      start = $urandom_range(0, 499) == 0;
      lap_cross = $urandom_range(0, 29) == 0;
      if ($urandom_range(0, 199) == 0) pause = ~pause;
    end
    @(negedge pclk);
    start = 1'b0; lap_cross = 1'b0; pause = 1'b0;
    pulse(1, 0); ticks(10); pause = 1'b1;
    repeat (3) @(negedge pclk);
    force dut.current_time = 24'h995998;
    force_sat = 1'b1;
    @(negedge pclk);
    release dut.current_time;
    force_sat = 1'b0;
    repeat (2) @(negedge pclk);
    pause = 1'b0; ticks(5); ticks(2);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({current_time, last_time, best_time, best_valid, lap_num, running, race_done, new_best} === 80'd0)
      passed++;
    else $display("FAIL async_reset got cur=%h last=%h best=%h bv=%b lap=%0d run=%b done=%b nb=%b exp all zero",
                  current_time, last_time, best_time, best_valid, lap_num, running, race_done, new_best);
    repeat (3) @(negedge pclk);
    rst = 1'b0;
    repeat (3) @(negedge pclk);
    #2;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
